// File: rtl/cp0_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl_pkg
// Description : Shared constants for the CP0 exception/interrupt controller.
//               Holds the register numbers, the exception codes used by the
//               controller, the PRId value and the field bit positions of
//               SR and Cause.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_ctrl_pkg;

    // CP0 register numbers
    localparam logic [4:0] c_reg_badvaddr = 5'd8;
    localparam logic [4:0] c_reg_sr       = 5'd12;
    localparam logic [4:0] c_reg_cause    = 5'd13;
    localparam logic [4:0] c_reg_epc      = 5'd14;
    localparam logic [4:0] c_reg_prid     = 5'd15;

    // Exception codes
    localparam logic [4:0] c_exc_int      = 5'd0;
    localparam logic [4:0] c_exc_adel     = 5'd4;
    localparam logic [4:0] c_exc_ades     = 5'd5;
    localparam logic [4:0] c_exc_ri       = 5'd10;
    localparam logic [4:0] c_exc_ov       = 5'd12;

    // Processor identification value
    localparam logic [31:0] c_prid_value  = 32'h0000_2023;

    // SR field positions
    localparam int c_sr_im_hi     = 15;
    localparam int c_sr_im_lo     = 10;
    localparam int c_sr_exl_bit   = 1;
    localparam int c_sr_ie_bit    = 0;

    // Cause field positions
    localparam int c_cause_bd_bit = 31;
    localparam int c_cause_ip_hi  = 15;
    localparam int c_cause_ip_lo  = 10;
    localparam int c_cause_exc_hi = 6;
    localparam int c_cause_exc_lo = 2;

endpackage : cp0_ctrl_pkg
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl
// Description : Coprocessor-0 controller. Holds SR, Cause, EPC and PRId,
//               raises the flush/redirect request for interrupts and
//               exceptions seen in the Memory stage, handles eret and
//               mtc0/mfc0 accesses.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk          in   1   pipeline clock, rising edge
//   reset        in   1   synchronous active-high reset
//   en           in   1   mtc0 write strobe
//   cp0_addr     in   5   register number for mtc0/mfc0
//   cp0_wdata    in   32  mtc0 write data
//   cp0_rdata    out  32  mfc0 read data (combinational, pre-edge value)
//   vpc          in   32  PC of the victim instruction
//   bd_in        in   1   victim sits in a branch delay slot
//   exc_code_in  in   5   pipelined exception code, 0 = none
//   hw_int       in   6   external interrupt lines
//   eret_in      in   1   eret in Memory stage
//   bad_vaddr_in in   32  faulting address (only with CP0_BADVADDR_EN)
//   req          out  1   flush/redirect request
//   epc_out      out  32  current EPC value
//
// Configuration macro:
//   CP0_BADVADDR_EN - adds bad_vaddr_in and the BadVAddr register (8).
//                     Without it, register 8 reads as zero.
// ============================================================================
module cp0_ctrl
    import cp0_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret_in,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] bad_vaddr_in,
`endif
    output logic        req,
    output logic [31:0] epc_out
);

    // Register state
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;
`endif

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_victim_epc;

    // Interrupts and exceptions are both masked while in handler mode (EXL=1).
    assign w_int_req    = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req    = (exc_code_in != c_exc_int) & ~r_sr_exl;
    assign req          = w_int_req | w_exc_req;

    // A delay-slot victim restarts at its branch.
    assign w_victim_epc = bd_in ? (vpc - 32'd4) : vpc;

    assign epc_out      = r_epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
`ifdef CP0_BADVADDR_EN
            r_badvaddr  <= '0;
`endif
        end else begin
            // Pending-interrupt bits mirror the lines every cycle.
            r_cause_ip <= hw_int;

            if (req) begin
                // Taking the trap: any coincident mtc0 or eret is discarded.
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bd_in;
                r_epc       <= w_victim_epc;
                r_cause_exc <= w_int_req ? c_exc_int : exc_code_in;
`ifdef CP0_BADVADDR_EN
                if (!w_int_req &&
                    ((exc_code_in == c_exc_adel) || (exc_code_in == c_exc_ades))) begin
                    r_badvaddr <= bad_vaddr_in;
                end
`endif
            end else begin
                if (eret_in) begin
                    r_sr_exl <= 1'b0;
                end
                // A coincident mtc0 SR is ordered after eret, so its EXL wins.
                if (en) begin
                    case (cp0_addr)
                        c_reg_sr: begin
                            r_sr_im  <= cp0_wdata[c_sr_im_hi:c_sr_im_lo];
                            r_sr_exl <= cp0_wdata[c_sr_exl_bit];
                            r_sr_ie  <= cp0_wdata[c_sr_ie_bit];
                        end
                        c_reg_epc: begin
                            r_epc <= cp0_wdata;
                        end
                        default: begin
                            // Cause, PRId and everything else are read-only.
                        end
                    endcase
                end
            end
        end
    end

    // mfc0 read mux
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            c_reg_sr:    cp0_rdata = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
            c_reg_cause: cp0_rdata = {r_cause_bd, 15'd0, r_cause_ip, 3'd0,
                                      r_cause_exc, 2'd0};
            c_reg_epc:   cp0_rdata = r_epc;
            c_reg_prid:  cp0_rdata = c_prid_value;
`ifdef CP0_BADVADDR_EN
            c_reg_badvaddr: cp0_rdata = r_badvaddr;
`endif
            default:     cp0_rdata = '0;
        endcase
    end

endmodule : cp0_ctrl
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_ctrl
// Description : Self-checking bench for cp0_ctrl. Directed vectors push
//               expected values into a scoreboard queue; a monitor process
//               pops each entry and compares it against the DUT output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret_in;
`ifdef CP0_BADVADDR_EN
    logic [31:0] bad_vaddr_in;
`endif
    logic        req;
    logic [31:0] epc_out;

    cp0_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret_in     (eret_in),
`ifdef CP0_BADVADDR_EN
        .bad_vaddr_in(bad_vaddr_in),
`endif
        .req         (req),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    localparam int c_k_req  = 0;
    localparam int c_k_epc  = 1;
    localparam int c_k_rd   = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;

    // Monitor: pops expected entries and compares them with the DUT outputs.
    initial begin
        item_t       it;
        logic [31:0] act;
        forever begin
            #1;
            if (sb.size() != 0) begin
                it = sb.pop_front();
                case (it.kind)
                    c_k_req: act = {31'd0, req};
                    c_k_epc: act = epc_out;
                    default: act = cp0_rdata;
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic post(input string nm, input int kind, input logic [31:0] exp);
        item_t it;
        it.name = nm;
        it.kind = kind;
        it.exp  = exp;
        sb.push_back(it);
        for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            $display("FAIL %s: scoreboard not drained", nm);
            $fatal(1, "scoreboard stalled");
        end
    endtask

    task automatic chk_req(input string nm, input logic exp);
        post(nm, c_k_req, {31'd0, exp});
    endtask

    task automatic chk_epc(input string nm, input logic [31:0] exp);
        post(nm, c_k_epc, exp);
    endtask

    task automatic chk_rd(input string nm, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        post(nm, c_k_rd, exp);
    endtask

    task automatic clear_inputs();
        en          = 1'b0;
        cp0_wdata   = '0;
        vpc         = '0;
        bd_in       = 1'b0;
        exc_code_in = '0;
        hw_int      = '0;
        eret_in     = 1'b0;
`ifdef CP0_BADVADDR_EN
        bad_vaddr_in = '0;
`endif
    endtask

    // Commit the currently driven inputs on the next edge, then return in the
    // low phase with inputs idle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        en        = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
    endtask

    initial begin
        reset    = 1'b1;
        cp0_addr = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk_req("rst_req", 1'b0);
        chk_epc("rst_epc_out", 32'h0);
        chk_rd ("rst_sr", 5'd12, 32'h0);
        chk_rd ("rst_cause", 5'd13, 32'h0);
        chk_rd ("rst_epc", 5'd14, 32'h0);
        chk_rd ("rst_prid", 5'd15, 32'h0000_2023);
        chk_rd ("rst_addr8", 5'd8, 32'h0);
        chk_rd ("rst_addr3", 5'd3, 32'h0);

        // Enable IM[10] and IE, then raise hw_int[0]
        mtc0(5'd12, 32'h0000_0401);
        chk_req("sr_wr_req", 1'b0);
        tick();
        hw_int = 6'b000001;
        vpc    = 32'h0000_1000;
        chk_req("int_req", 1'b1);
        tick();
        chk_rd ("int_cause", 5'd13, 32'h0000_0400);
        chk_rd ("int_sr", 5'd12, 32'h0000_0403);
        chk_rd ("int_epc", 5'd14, 32'h0000_1000);
        chk_epc("int_epc_out", 32'h0000_1000);
        chk_req("int_exl_req", 1'b0);

        // eret leaves handler mode, EPC untouched
        eret_in = 1'b1;
        chk_req("eret_req", 1'b0);
        tick();
        chk_rd ("eret_sr", 5'd12, 32'h0000_0401);
        chk_rd ("eret_cause", 5'd13, 32'h0);
        chk_epc("eret_epc_out", 32'h0000_1000);

        // Overflow in a delay slot
        exc_code_in = 5'd12;
        bd_in       = 1'b1;
        vpc         = 32'h0000_3010;
        chk_req("ov_req", 1'b1);
        tick();
        chk_rd ("ov_epc", 5'd14, 32'h0000_300C);
        chk_rd ("ov_cause", 5'd13, 32'h8000_0030);
        chk_rd ("ov_sr", 5'd12, 32'h0000_0403);

        // Exception while EXL=1: no request, only IP follows hw_int
        exc_code_in = 5'd10;
        hw_int      = 6'b000010;
        vpc         = 32'h0000_5000;
        chk_req("exl_ri_req", 1'b0);
        tick();
        chk_rd ("exl_cause", 5'd13, 32'h8000_0830);
        chk_rd ("exl_epc", 5'd14, 32'h0000_300C);
        chk_rd ("exl_sr", 5'd12, 32'h0000_0403);

        eret_in = 1'b1;
        tick();
        chk_rd ("eret2_sr", 5'd12, 32'h0000_0401);
        chk_rd ("eret2_cause", 5'd13, 32'h8000_0030);
        hw_int = 6'b000010;
        chk_req("masked_int_req", 1'b0);
        hw_int = 6'b000000;

        // mtc0 EPC collides with AdEL: write dropped
        mtc0(5'd14, 32'h0000_3100);
        exc_code_in = 5'd4;
        vpc         = 32'h0000_2000;
        chk_req("adel_req", 1'b1);
        tick();
        chk_rd ("adel_epc", 5'd14, 32'h0000_2000);
        chk_rd ("adel_cause", 5'd13, 32'h0000_0010);
        chk_rd ("adel_sr", 5'd12, 32'h0000_0403);

        eret_in = 1'b1;
        tick();
        chk_rd ("eret3_sr", 5'd12, 32'h0000_0401);

        // Interrupt outranks exception; coincident eret ignored
        hw_int      = 6'b000001;
        exc_code_in = 5'd5;
        bd_in       = 1'b1;
        vpc         = 32'h0000_4000;
        eret_in     = 1'b1;
        chk_req("prio_req", 1'b1);
        tick();
        chk_rd ("prio_cause", 5'd13, 32'h8000_0400);
        chk_rd ("prio_epc", 5'd14, 32'h0000_3FFC);
        chk_rd ("prio_sr", 5'd12, 32'h0000_0403);

        // Read-only and masked writes while in handler mode
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_req("cause_wr_req", 1'b0);
        tick();
        chk_rd ("cause_ro", 5'd13, 32'h8000_0000);
        mtc0(5'd12, 32'hFFFF_FFFF);
        tick();
        chk_rd ("sr_mask", 5'd12, 32'h0000_FC03);
        mtc0(5'd15, 32'h0000_0000);
        tick();
        chk_rd ("prid_ro", 5'd15, 32'h0000_2023);
        mtc0(5'd14, 32'h0000_3008);
        tick();
        chk_epc("epc_wr_out", 32'h0000_3008);

        // Reset mid-handler overrides every coincident event
        reset = 1'b1;
        mtc0(5'd12, 32'h0000_0401);
        exc_code_in = 5'd12;
        eret_in     = 1'b1;
        hw_int      = 6'b111111;
        tick();
        reset = 1'b0;
        chk_rd ("rst2_sr", 5'd12, 32'h0);
        chk_rd ("rst2_cause", 5'd13, 32'h0);
        chk_rd ("rst2_epc", 5'd14, 32'h0);
        chk_epc("rst2_epc_out", 32'h0);
        chk_req("rst2_req", 1'b0);
        chk_rd ("rst2_prid", 5'd15, 32'h0000_2023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cp0_ctrl
`default_nettype wire
